// File: rtl/fcvt_f2i_pipe.sv
// Two-stage float32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S).
// Define FCVT_F2I_FFLAGS_EN to build the NV/NX flag path.
module fcvt_f2i_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [2:0]  rm,
    input  logic        is_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    logic out_load;
    logic s1_load;

    logic        s1_valid_q;
    logic [31:0] s1_int_q;
    logic        s1_g_q;
    logic        s1_s_q;
    logic        s1_sign_q;
    logic        s1_nan_q;
    logic        s1_huge_q;
    logic [2:0]  s1_rm_q;
    logic        s1_uns_q;

    logic        out_valid_q;
    logic [31:0] result_q;

    assign out_load = !out_valid_q | out_ready;
    assign s1_load  = !s1_valid_q | out_load;
    assign in_ready = s1_load;

    // Stage 1: unpack and align
    logic        a_sign;
    logic [7:0]  a_exp;
    logic [22:0] a_man;
    logic [23:0] a_sig;
    logic signed [9:0] a_e;
    logic [4:0]  rsh;
    logic [3:0]  lsh;
    logic [47:0] rtmp;
    logic [31:0] ltmp;
    logic [31:0] int_d;
    logic        g_d;
    logic        s_d;
    logic        nan_d;
    logic        huge_d;
    logic        normal;

    assign a_sign = op_a[31];
    assign a_exp  = op_a[30:23];
    assign a_man  = op_a[22:0];
    assign a_sig  = {(a_exp != 8'd0), a_man};
    assign a_e    = $signed({2'b00, a_exp}) - 10'sd127;
    // Low bits suffice: right shifts only for e in [-1,22], left for [23,31]
    assign rsh    = 5'd23 - a_e[4:0];
    assign lsh    = a_e[3:0] - 4'd7;
    assign rtmp   = {a_sig, 24'b0} >> rsh;
    assign ltmp   = {8'b0, a_sig} << lsh;
    assign normal = (a_exp != 8'd0) && (a_exp != 8'hFF);

    always_comb begin
        int_d  = 32'd0;
        g_d    = 1'b0;
        s_d    = 1'b0;
        nan_d  = (a_exp == 8'hFF) && (a_man != 23'd0);
        huge_d = (a_exp == 8'hFF) && (a_man == 23'd0);
        if (a_exp == 8'd0) begin
            s_d = (a_man != 23'd0);
        end else if (normal) begin
            if (a_e >= 10'sd32) begin
                huge_d = 1'b1;
            end else if (a_e >= 10'sd23) begin
                int_d = ltmp;
            end else if (a_e >= -10'sd1) begin
                int_d = {8'b0, rtmp[47:24]};
                g_d   = rtmp[23];
                s_d   = |rtmp[22:0];
            end else begin
                s_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_int_q   <= 32'd0;
            s1_g_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_huge_q  <= 1'b0;
            s1_rm_q    <= 3'd0;
            s1_uns_q   <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_int_q  <= int_d;
                s1_g_q    <= g_d;
                s1_s_q    <= s_d;
                s1_sign_q <= a_sign;
                s1_nan_q  <= nan_d;
                s1_huge_q <= huge_d;
                s1_rm_q   <= rm;
                s1_uns_q  <= is_unsigned;
            end
        end
    end

    // Stage 2: round and saturate
    logic        inc;
    logic [32:0] mag;
    logic        inv;
    logic        sat_pos;
    logic [31:0] result_d;

    always_comb begin
        case (s1_rm_q)
            3'b000:  inc = s1_g_q & (s1_s_q | s1_int_q[0]);
            3'b010:  inc = s1_sign_q & (s1_g_q | s1_s_q);
            3'b011:  inc = ~s1_sign_q & (s1_g_q | s1_s_q);
            3'b100:  inc = s1_g_q;
            default: inc = 1'b0;
        endcase
    end

    assign mag     = {1'b0, s1_int_q} + {32'd0, inc};
    assign sat_pos = s1_nan_q | ~s1_sign_q;

    always_comb begin
        inv = s1_nan_q | s1_huge_q;
        if (s1_uns_q) begin
            if (s1_sign_q) inv = inv | (mag != 33'd0);
            else           inv = inv | mag[32];
        end else begin
            if (s1_sign_q) inv = inv | mag[32] | (mag[31] & |mag[30:0]);
            else           inv = inv | mag[32] | mag[31];
        end
    end

    always_comb begin
        if (inv) begin
            if (s1_uns_q) result_d = sat_pos ? 32'hFFFF_FFFF : 32'h0000_0000;
            else          result_d = sat_pos ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (s1_sign_q && !s1_uns_q) begin
            result_d = 32'd0 - mag[31:0];
        end else begin
            result_d = mag[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
        end else if (out_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) result_q <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef FCVT_F2I_FFLAGS_EN
    logic [4:0] fflags_q;
    logic [4:0] fflags_d;

    assign fflags_d = {inv, 3'b000, (s1_g_q | s1_s_q) & ~inv};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fflags_q <= 5'd0;
        end else if (out_load && s1_valid_q) begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;
`else
    assign fflags = 5'b0;
`endif

endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// Directed bench for fcvt_f2i_pipe: rounding modes, boundaries,
// specials, backpressure and mid-stream reset.
module tb_fcvt_f2i_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [2:0]  rm;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] NX = 5'b00001;
    localparam logic [4:0] NF = 5'b00000;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    fcvt_f2i_pipe dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .rm          (rm),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .fflags      (fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic conv(input string tag, input logic [31:0] a,
                        input logic [2:0] r, input logic u,
                        input logic [31:0] er, input logic [4:0] ef);
        logic       seen;
        logic [4:0] fe;
`ifdef FCVT_F2I_FFLAGS_EN
        fe = ef;
`else
        fe = 5'b0;
`endif
        op_a = a;
        rm = r;
        is_unsigned = u;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, ".valid"}, {31'd0, seen}, 32'd1);
        chk({tag, ".res"}, result, er);
        chk({tag, ".flags"}, {27'd0, fflags}, {27'd0, fe});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_ops [4];
    logic [31:0] bp_exp [4];
    int issued;
    int got;
    logic in_fire;
    logic out_fire;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        op_a = 32'd0;
        rm = 3'd0;
        is_unsigned = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.fflags", {27'd0, fflags}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        conv("p25.rne", 32'h40200000, RNE, 1'b0, 32'h00000002, NX);
        conv("p25.rmm", 32'h40200000, RMM, 1'b0, 32'h00000003, NX);
        conv("p25.rup", 32'h40200000, RUP, 1'b0, 32'h00000003, NX);
        conv("p25.rdn", 32'h40200000, RDN, 1'b0, 32'h00000002, NX);
        conv("p25.rtz", 32'h40200000, RTZ, 1'b0, 32'h00000002, NX);
        conv("n25.rdn", 32'hC0200000, RDN, 1'b0, 32'hFFFFFFFD, NX);
        conv("n25.rtz", 32'hC0200000, RTZ, 1'b0, 32'hFFFFFFFE, NX);
        conv("n25.rne", 32'hC0200000, RNE, 1'b0, 32'hFFFFFFFE, NX);
        conv("p2e31.s", 32'h4F000000, RNE, 1'b0, 32'h7FFFFFFF, NV);
        conv("p2e31.u", 32'h4F000000, RNE, 1'b1, 32'h80000000, NF);
        conv("n2e31.s", 32'hCF000000, RNE, 1'b0, 32'h80000000, NF);
        conv("nan.s", 32'h7FC00000, RNE, 1'b0, 32'h7FFFFFFF, NV);
        conv("nan.u", 32'h7FC00000, RNE, 1'b1, 32'hFFFFFFFF, NV);
        conv("ninf.u", 32'hFF800000, RNE, 1'b1, 32'h00000000, NV);
        conv("ninf.s", 32'hFF800000, RNE, 1'b0, 32'h80000000, NV);
        conv("sub.rup", 32'h00000001, RUP, 1'b0, 32'h00000001, NX);
        conv("nhalf.rne", 32'hBF000000, RNE, 1'b1, 32'h00000000, NX);
        conv("nhalf.rdn", 32'hBF000000, RDN, 1'b1, 32'h00000000, NV);
        conv("nzero.s", 32'h80000000, RDN, 1'b0, 32'h00000000, NF);
        conv("rm7.rtz", 32'h40600000, 3'd7, 1'b0, 32'h00000003, NX);

        bp_ops[0] = 32'h3F800000;
        bp_ops[1] = 32'h40000000;
        bp_ops[2] = 32'h40400000;
        bp_ops[3] = 32'h40800000;
        bp_exp[0] = 32'd1;
        bp_exp[1] = 32'd2;
        bp_exp[2] = 32'd3;
        bp_exp[3] = 32'd4;
        issued = 0;
        got = 0;
        rm = RTZ;
        is_unsigned = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            in_valid = (issued < 4);
            op_a = bp_ops[issued < 4 ? issued : 3];
            out_ready = (cyc >= 3);
            @(negedge clk);
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (cyc == 2) begin
                chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp.accepts", issued, 2);
            end
            if (out_valid && !out_ready)
                chk("bp.stall_res", result, bp_exp[got]);
            if (out_fire) begin
                chk("bp.order", result, bp_exp[got]);
                got++;
            end
            if (in_fire) issued++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp.count", got, 4);

        out_ready = 1'b0;
        op_a = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mr.pre_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr.result", result, 32'd0);
        chk("mr.fflags", {27'd0, fflags}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("mr.no_ghost", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
